wb_stage: RTL and testbench

- Registered write-back stage for the pipelined CPU. It replaces the purely combinational MEM-to-register-file mux with a MEM/WB holding stage.
- Accepts one instruction per cycle from MEM through a valid/ready handshake, waits for late load data, and sign- or zero-extends sub-word loads.
- Issues a single-cycle register-file write and exposes forwarding/pending information to the hazard unit.

---
 rtl/wb_stage.sv | 197 +++++++++++++++++++
 tb/tb_wb_stage.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// wb_stage: registered MEM/WB write-back stage.
// Accepts one instruction per cycle from MEM, waits for late load data,
// extends sub-word loads and issues a single-cycle register-file write.
// Optional retire counter enabled by defining WB_PERF_CNT_EN.
// o_dbg_state exposes the FSM state (EMPTY=0, WAIT=1, WRITE=2) for checkers.

module wb_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          mem_valid,
    output logic                          mem_ready,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             mem_alu_result,
    input  logic [REG_AW-1:0]             mem_write_reg,
    input  logic [1:0]                    mem_control_wb,
    input  logic [2:0]                    mem_load_type,
    input  logic [$clog2(DATA_W/8)-1:0]   mem_byte_off,
    input  logic [DATA_W-1:0]             read_data,
    input  logic                          read_data_valid,
    output logic [DATA_W-1:0]             write_data,
    output logic [REG_AW-1:0]             write_reg,
    output logic                          reg_write,
    output logic                          fwd_pending,
    output logic [REG_AW-1:0]             fwd_reg,
    output logic [CNT_W-1:0]              retire_count,
    output logic [1:0]                    o_dbg_state
);

    localparam int OFF_W = $clog2(DATA_W/8);

    localparam logic [2:0] LT_LH  = 3'b001;
    localparam logic [2:0] LT_LHU = 3'b010;
    localparam logic [2:0] LT_LB  = 3'b011;
    localparam logic [2:0] LT_LBU = 3'b100;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [REG_AW-1:0]   r_dest;
    logic                r_regwrite;
    logic [2:0]          r_load_type;
    logic [OFF_W-1:0]    r_byte_off;
    logic [DATA_W-1:0]   r_write_data;
    logic [REG_AW-1:0]   r_write_reg;

    logic                w_accept;
    logic                w_commit_en;
    logic [DATA_W-1:0]   w_commit_data;
    logic [REG_AW-1:0]   w_commit_reg;
    logic [DATA_W-1:0]   w_ext_now;
    logic [DATA_W-1:0]   w_ext_wait;

    // Select the byte/halfword lane and sign- or zero-extend it.
    // Halfword lanes ignore bit 0 of the byte offset; unknown types read as LW.
    function automatic logic [DATA_W-1:0] f_ext(
        input logic [DATA_W-1:0] d,
        input logic [2:0]        ltype,
        input logic [OFF_W-1:0]  off
    );
        logic [DATA_W-1:0] sh_b;
        logic [DATA_W-1:0] sh_h;
        logic [OFF_W-1:0]  off_h;
        logic [DATA_W-1:0] res;
        off_h = {off[OFF_W-1:1], 1'b0};
        sh_b  = d >> {off, 3'b000};
        sh_h  = d >> {off_h, 3'b000};
        case (ltype)
            LT_LH:   res = {{(DATA_W-16){sh_h[15]}}, sh_h[15:0]};
            LT_LHU:  res = {{(DATA_W-16){1'b0}},     sh_h[15:0]};
            LT_LB:   res = {{(DATA_W-8){sh_b[7]}},   sh_b[7:0]};
            LT_LBU:  res = {{(DATA_W-8){1'b0}},      sh_b[7:0]};
            default: res = d;
        endcase
        return res;
    endfunction

    // Handshake: a transfer happens in a cycle where mem_valid and mem_ready
    // are both high and flush is low. mem_ready depends only on the current
    // state (low only while waiting for load data), never on mem_valid.
    assign mem_ready = (r_state != ST_WAIT);
    assign w_accept  = mem_valid & mem_ready & ~flush;

    // Same-cycle load data uses the incoming type/offset; late data uses the latched copy.
    assign w_ext_now  = f_ext(read_data, mem_load_type, mem_byte_off);
    assign w_ext_wait = f_ext(read_data, r_load_type, r_byte_off);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and commit-data selection.
    always_comb begin
        w_next_state  = r_state;
        w_commit_en   = 1'b0;
        w_commit_data = r_write_data;
        w_commit_reg  = r_write_reg;
        case (r_state)
            ST_EMPTY, ST_WRITE: begin
                // WRITE always leaves after one cycle; a new accept gives back-to-back.
                w_next_state = ST_EMPTY;
                if (w_accept) begin
                    if (!mem_control_wb[0]) begin
                        w_commit_en   = 1'b1;
                        w_commit_data = mem_alu_result;
                        w_commit_reg  = mem_write_reg;
                        w_next_state  = ST_WRITE;
                    end else if (read_data_valid) begin
                        w_commit_en   = 1'b1;
                        w_commit_data = w_ext_now;
                        w_commit_reg  = mem_write_reg;
                        w_next_state  = ST_WRITE;
                    end else begin
                        w_next_state  = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // flush wins over arriving data: the load is dropped without a write.
                if (flush) begin
                    w_next_state = ST_EMPTY;
                end else if (read_data_valid) begin
                    w_commit_en   = 1'b1;
                    w_commit_data = w_ext_wait;
                    w_commit_reg  = r_dest;
                    w_next_state  = ST_WRITE;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
    end

    // Latch instruction fields on accept; update the write port only when entering WRITE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dest       <= '0;
            r_regwrite   <= 1'b0;
            r_load_type  <= '0;
            r_byte_off   <= '0;
            r_write_data <= '0;
            r_write_reg  <= '0;
        end else begin
            if (w_accept) begin
                r_dest      <= mem_write_reg;
                r_regwrite  <= mem_control_wb[1];
                r_load_type <= mem_load_type;
                r_byte_off  <= mem_byte_off;
            end
            if (w_commit_en) begin
                r_write_data <= w_commit_data;
                r_write_reg  <= w_commit_reg;
            end
        end
    end

    assign write_data  = r_write_data;
    assign write_reg   = r_write_reg;
    // Writes to r0 are suppressed so the register file never sees them.
    assign reg_write   = (r_state == ST_WRITE) & r_regwrite & (r_write_reg != '0);
    assign fwd_pending = (r_state == ST_WAIT);
    assign fwd_reg     = (r_state == ST_EMPTY) ? '0 : r_dest;
    assign o_dbg_state = r_state;

`ifdef WB_PERF_CNT_EN
    logic [CNT_W-1:0] r_retire_count;

    // Count committed writes; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_count <= '0;
        end else if (reg_write) begin
            r_retire_count <= r_retire_count + 1'b1;
        end
    end

    assign retire_count = r_retire_count;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: self-checking bench for wb_stage.
// Directed scenarios plus a randomized sweep against a behavioural model.

module tb_wb_stage;

    logic        clk;
    logic        rst_n;
    logic        mem_valid;
    logic        mem_ready;
    logic        flush;
    logic [31:0] mem_alu_result;
    logic [4:0]  mem_write_reg;
    logic [1:0]  mem_control_wb;
    logic [2:0]  mem_load_type;
    logic [1:0]  mem_byte_off;
    logic [31:0] read_data;
    logic        read_data_valid;
    logic [31:0] write_data;
    logic [4:0]  write_reg;
    logic        reg_write;
    logic        fwd_pending;
    logic [4:0]  fwd_reg;
    logic [31:0] retire_count;
    logic [1:0]  dbg_state;

    int checks = 0;
    int errors = 0;
    int exp_commits = 0;
    logic [31:0] exp_q[$];

    wb_stage #(.DATA_W(32), .REG_AW(5), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .flush(flush),
        .mem_alu_result(mem_alu_result), .mem_write_reg(mem_write_reg),
        .mem_control_wb(mem_control_wb), .mem_load_type(mem_load_type),
        .mem_byte_off(mem_byte_off), .read_data(read_data),
        .read_data_valid(read_data_valid), .write_data(write_data),
        .write_reg(write_reg), .reg_write(reg_write),
        .fwd_pending(fwd_pending), .fwd_reg(fwd_reg),
        .retire_count(retire_count), .o_dbg_state(dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Reference model: extract lane from a word and extend it.
    function automatic logic [31:0] ref_ext(input logic [31:0] d, input int t, input int off);
        logic [31:0] v;
        int lane;
        case (t)
            1, 2: begin
                lane = (off / 2) * 2;
                v = (d >> (8 * lane)) & 32'hFFFF;
                if (t == 1 && v >= 32'h8000) v = v + 32'hFFFF0000;
            end
            3, 4: begin
                v = (d >> (8 * off)) & 32'hFF;
                if (t == 3 && v >= 32'h80) v = v + 32'hFFFFFF00;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_retire();
`ifdef WB_PERF_CNT_EN
        return exp_commits;
`else
        return 32'd0;
`endif
    endfunction

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_op(input logic ld, input logic regw, input logic [4:0] rd,
                            input logic [31:0] alu, input logic [2:0] lt, input logic [1:0] off);
        mem_valid      = 1'b1;
        mem_control_wb = {regw, ld};
        mem_write_reg  = rd;
        mem_alu_result = alu;
        mem_load_type  = lt;
        mem_byte_off   = off;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        flush = 1'b0;
        read_data_valid = 1'b0;
        read_data = '0;
        mem_alu_result = '0; mem_write_reg = '0; mem_control_wb = '0;
        mem_load_type = '0; mem_byte_off = '0;
        tick(); tick();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write got %b exp 0", reg_write); end
        checks++; if (write_data !== 32'h0) begin errors++; $display("FAIL reset_write_data got %h exp 0", write_data); end
        checks++; if (write_reg !== 5'd0) begin errors++; $display("FAIL reset_write_reg got %0d exp 0", write_reg); end
        checks++; if (fwd_pending !== 1'b0 || fwd_reg !== 5'd0) begin errors++; $display("FAIL reset_fwd got %b/%0d exp 0/0", fwd_pending, fwd_reg); end
        checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready got %b exp 1", mem_ready); end
        checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL reset_retire got %0d exp 0", retire_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        drive_op(1'b0, 1'b1, 5'd5, 32'h0000_1234, 3'd0, 2'd0);
        tick(); idle();
        checks++; if (reg_write !== 1'b1) begin errors++; $display("FAIL alu_reg_write got %b exp 1", reg_write); end
        checks++; if (write_reg !== 5'd5) begin errors++; $display("FAIL alu_write_reg got %0d exp 5", write_reg); end
        checks++; if (write_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_write_data got %h exp 00001234", write_data); end
        exp_commits++;
        tick();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL alu_pulse_end got %b exp 0", reg_write); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) begin
                checks++; if (reg_write !== 1'b1 || write_reg !== i[4:0] || write_data !== 32'hA000_0000 + i)
                    begin errors++; $display("FAIL b2b_write%0d got %b/%0d/%h exp 1/%0d/%h", i, reg_write, write_reg, write_data, i, 32'hA000_0000 + i); end
                exp_commits++;
            end
            if (i < 3) drive_op(1'b0, 1'b1, 5'(i + 1), 32'hA000_0000 + (i + 1), 3'd0, 2'd0);
            else idle();
            checks++; if (mem_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d got %b exp 1", i, mem_ready); end
            tick();
        end
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL b2b_end got %b exp 0", reg_write); end
    endtask

    task automatic test_byte_loads();
        // LB, data three cycles after accept
        drive_op(1'b1, 1'b1, 5'd7, 32'h0, 3'd3, 2'd1);
        read_data_valid = 1'b0;
        tick(); idle();
        for (int k = 1; k <= 3; k++) begin
            checks++; if (mem_ready !== 1'b0 || fwd_pending !== 1'b1 || fwd_reg !== 5'd7 || reg_write !== 1'b0)
                begin errors++; $display("FAIL lb_wait%0d got rdy=%b pend=%b reg=%0d wr=%b exp 0/1/7/0", k, mem_ready, fwd_pending, fwd_reg, reg_write); end
            if (k == 3) begin read_data = 32'h1122_83FF; read_data_valid = 1'b1; end
            tick();
        end
        read_data_valid = 1'b0;
        checks++; if (reg_write !== 1'b1 || write_reg !== 5'd7 || write_data !== 32'hFFFF_FF83)
            begin errors++; $display("FAIL lb_data got %b/%0d/%h exp 1/7/ffffff83", reg_write, write_reg, write_data); end
        exp_commits++;
        tick();
        // LBU of the same word, data in the accept cycle
        drive_op(1'b1, 1'b1, 5'd8, 32'h0, 3'd4, 2'd1);
        read_data = 32'h1122_83FF; read_data_valid = 1'b1;
        tick(); idle(); read_data_valid = 1'b0;
        checks++; if (reg_write !== 1'b1 || write_data !== 32'h0000_0083)
            begin errors++; $display("FAIL lbu_data got %b/%h exp 1/00000083", reg_write, write_data); end
        exp_commits++;
        tick();
    endtask

    task automatic test_half_loads();
        drive_op(1'b1, 1'b1, 5'd9, 32'h0, 3'd1, 2'd2);
        read_data = 32'h8001_0000; read_data_valid = 1'b1;
        tick(); idle(); read_data_valid = 1'b0;
        checks++; if (reg_write !== 1'b1 || write_data !== 32'hFFFF_8001)
            begin errors++; $display("FAIL lh_data got %b/%h exp 1/ffff8001", reg_write, write_data); end
        exp_commits++;
        tick();
        // LHU with offset 3: bit 0 ignored, data one cycle late
        drive_op(1'b1, 1'b1, 5'd10, 32'h0, 3'd2, 2'd3);
        read_data_valid = 1'b0;
        tick(); idle();
        read_data = 32'h8001_0000; read_data_valid = 1'b1;
        tick(); read_data_valid = 1'b0;
        checks++; if (reg_write !== 1'b1 || write_data !== 32'h0000_8001)
            begin errors++; $display("FAIL lhu_data got %b/%h exp 1/00008001", reg_write, write_data); end
        exp_commits++;
        tick();
    endtask

    task automatic test_r0();
        drive_op(1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF, 3'd0, 2'd0);
        tick(); idle();
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL r0_reg_write got %b exp 0", reg_write); end
        tick();
        checks++; if (retire_count !== exp_retire()) begin errors++; $display("FAIL r0_retire got %0d exp %0d", retire_count, exp_retire()); end
    endtask

    task automatic test_flush_wait();
        drive_op(1'b1, 1'b1, 5'd11, 32'h0, 3'd0, 2'd0);
        read_data_valid = 1'b0;
        tick(); idle();
        flush = 1'b1; read_data = 32'h5555_AAAA; read_data_valid = 1'b1;
        tick();
        flush = 1'b0; read_data_valid = 1'b0;
        checks++; if (reg_write !== 1'b0 || mem_ready !== 1'b1 || fwd_pending !== 1'b0)
            begin errors++; $display("FAIL flush_wait got wr=%b rdy=%b pend=%b exp 0/1/0", reg_write, mem_ready, fwd_pending); end
        // stray data after the flush must not resurrect the load
        read_data_valid = 1'b1;
        tick(); read_data_valid = 1'b0;
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL flush_stray got %b exp 0", reg_write); end
        tick();
    endtask

    task automatic test_flush_write();
        drive_op(1'b0, 1'b1, 5'd12, 32'h0BAD_F00D, 3'd0, 2'd0);
        tick();
        drive_op(1'b0, 1'b1, 5'd13, 32'h1111_2222, 3'd0, 2'd0);
        flush = 1'b1;
        checks++; if (reg_write !== 1'b1 || write_data !== 32'h0BAD_F00D)
            begin errors++; $display("FAIL flush_write_commit got %b/%h exp 1/0badf00d", reg_write, write_data); end
        exp_commits++;
        tick(); idle(); flush = 1'b0;
        checks++; if (reg_write !== 1'b0 || write_reg !== 5'd12)
            begin errors++; $display("FAIL flush_write_block got %b/%0d exp 0/12", reg_write, write_reg); end
        tick();
    endtask

    task automatic test_reset_wait();
        drive_op(1'b1, 1'b1, 5'd14, 32'h0, 3'd0, 2'd0);
        read_data_valid = 1'b0;
        tick(); idle();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (write_data !== 32'h0 || write_reg !== 5'd0 || reg_write !== 1'b0 || fwd_pending !== 1'b0 || fwd_reg !== 5'd0 || retire_count !== 32'd0 || mem_ready !== 1'b1)
            begin errors++; $display("FAIL reset_wait got wd=%h wr=%0d we=%b pend=%b freg=%0d cnt=%0d rdy=%b exp all 0, rdy 1", write_data, write_reg, reg_write, fwd_pending, fwd_reg, retire_count, mem_ready); end
        exp_commits = 0;
        tick();
        rst_n = 1'b1;
        read_data = 32'h7777_7777; read_data_valid = 1'b1;
        tick(); read_data_valid = 1'b0;
        checks++; if (reg_write !== 1'b0) begin errors++; $display("FAIL reset_wait_no_write got %b exp 0", reg_write); end
        tick();
    endtask

    task automatic test_random();
        logic        ld, regw;
        logic [4:0]  rd;
        logic [31:0] alu, rdata, exp_data;
        logic [2:0]  lt;
        logic [1:0]  off;
        int          dly;
        for (int i = 0; i < 40; i++) begin
            ld = 1'($urandom_range(0, 1));
            regw = ($urandom_range(0, 3) != 0);
            rd = 5'($urandom_range(0, 31));
            alu = $urandom; rdata = $urandom;
            lt = 3'($urandom_range(0, 7));
            off = 2'($urandom_range(0, 3));
            dly = $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                read_data = $urandom; read_data_valid = 1'b1;
                tick(); read_data_valid = 1'b0;
                checks++; if (reg_write !== 1'b0 || mem_ready !== 1'b1)
                    begin errors++; $display("FAIL rnd%0d_stray got %b/%b exp 0/1", i, reg_write, mem_ready); end
            end
            exp_q.push_back(ld ? ref_ext(rdata, int'(lt), int'(off)) : alu);
            drive_op(ld, regw, rd, alu, lt, off);
            if (ld && dly == 0) begin read_data = rdata; read_data_valid = 1'b1; end
            else begin read_data = $urandom; read_data_valid = 1'b0; end
            tick(); idle(); read_data_valid = 1'b0;
            if (ld && dly > 0) begin
                for (int k = 1; k <= dly; k++) begin
                    checks++; if (mem_ready !== 1'b0 || fwd_pending !== 1'b1 || fwd_reg !== rd)
                        begin errors++; $display("FAIL rnd%0d_wait got %b/%b/%0d exp 0/1/%0d", i, mem_ready, fwd_pending, fwd_reg, rd); end
                    if (k == dly) begin read_data = rdata; read_data_valid = 1'b1; end
                    tick();
                end
                read_data_valid = 1'b0;
            end
            exp_data = exp_q.pop_front();
            checks++; if (reg_write !== (regw && rd != 5'd0) || write_data !== exp_data || write_reg !== rd)
                begin errors++; $display("FAIL rnd%0d_commit got %b/%0d/%h exp %b/%0d/%h", i, reg_write, write_reg, write_data, regw && rd != 5'd0, rd, exp_data); end
            checks++; if (retire_count !== exp_retire())
                begin errors++; $display("FAIL rnd%0d_retire got %0d exp %0d", i, retire_count, exp_retire()); end
            if (regw && rd != 5'd0) exp_commits++;
            tick();
        end
        checks++; if (retire_count !== exp_retire())
            begin errors++; $display("FAIL rnd_retire_final got %0d exp %0d", retire_count, exp_retire()); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_byte_loads();
        test_half_loads();
        test_r0();
        test_flush_wait();
        test_flush_write();
        test_reset_wait();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
